tx_playback_core: RTL and testbench

TX_PLAYBACK_CORE -- requirements
Module: tx_playback_core

---
 rtl/tx_core_pkg.sv | 32 +++
 rtl/tx_sample_buffer.sv | 30 +++
 rtl/tx_playback_core.sv | 173 +++++++++++++++++
 tb/tb_tx_playback_core.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_core_pkg.sv
// Shared types and arithmetic helpers for the TX playback core.
// Holds the FSM state encoding, the sample and gain widths, and the saturating Q1.15 rescale.
package tx_core_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int GAIN_FRAC = 15;
  localparam int PROD_W    = 2 * SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } tx_state_e;

  // Arithmetic shift right by GAIN_FRAC, which floors the value (truncates toward minus infinity).
  // The result is then clamped to the signed SAMPLE_W range. The shifted value fits only when
  // every bit from the sample sign bit upward is the same.
  function automatic logic [SAMPLE_W-1:0] saturate(input logic [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    logic [PROD_W-SAMPLE_W:0] hi;
    shifted = $signed(prod) >>> GAIN_FRAC;
    hi      = shifted[PROD_W-1:SAMPLE_W-1];
    if ((&hi) || (~|hi)) begin
      return shifted[SAMPLE_W-1:0];
    end else if (shifted[PROD_W-1]) begin
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/tx_sample_buffer.sv
// Simple dual-port waveform RAM. It has one write port and one registered read port.
// Read latency is one clock, and there is no reset on the storage.
module tx_sample_buffer #(
  parameter int WIDTH      = 128,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tx_playback_core.sv
// Arbitrary-waveform playback engine. It has an arm/trigger/stop FSM and loops over a stored buffer.
// Each output passes through a 3-stage pipeline: buffer read, per-lane gain multiply, then shift/saturate.
module tx_playback_core
  import tx_core_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DEPTH_LOG2-1:0]              wr_addr,
  input  logic [SAMPLE_W*NUMBER_OF_LINE-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]              last_addr,
  input  logic [15:0]                        loop_count,
  input  logic [SAMPLE_W-1:0]                gain,
  input  logic                               arm,
  input  logic                               trigger,
  input  logic                               stop,
  output logic [SAMPLE_W*NUMBER_OF_LINE-1:0] dac_data,
  output logic                               dac_valid,
  output logic                               busy,
  output logic                               done,
  output tx_state_e                          state_dbg
);

  localparam int WORD_W = SAMPLE_W * NUMBER_OF_LINE;

  // Write handshake: a word is stored on any edge where wr_valid && wr_ready.
  // wr_ready is low only during PLAY, so a write offered then is dropped, not held.
  tx_state_e             state_q;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic [DEPTH_LOG2-1:0] last_q;
  logic [15:0]           rem_q;
  logic                  inf_q;
  logic [SAMPLE_W-1:0]   gain_q;
  logic                  final_rd;
  logic                  rd_en;
  logic                  wr_en;
  logic [WORD_W-1:0]     rd_data;

  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic                  s2_valid_q;
  logic                  s2_last_q;
  logic [NUMBER_OF_LINE-1:0][PROD_W-1:0] prod_d;
  logic [NUMBER_OF_LINE-1:0][PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] gain_ext;

  logic [WORD_W-1:0]     dac_data_d;
  logic [WORD_W-1:0]     dac_data_q;
  logic                  dac_valid_q;
  logic                  done_q;

  assign wr_en    = wr_valid && wr_ready;
  assign rd_en    = (state_q == ST_PLAY);
  assign final_rd = (state_q == ST_PLAY) && (rd_addr_q == last_q) && !inf_q && (rem_q <= 16'd1);

  tx_sample_buffer #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_buf (
    .clk_i     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (rd_data)
  );

  // Control FSM. It also produces stage 1 of the pipeline, the valid and last flags for the word being read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      last_q     <= '0;
      rem_q      <= '0;
      inf_q      <= 1'b0;
      gain_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arm && !stop) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (trigger) begin
            state_q   <= ST_PLAY;
            last_q    <= last_addr;
            rem_q     <= loop_count;
            inf_q     <= (loop_count == 16'd0);
            gain_q    <= gain;
            rd_addr_q <= '0;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else begin
            s1_valid_q <= 1'b1;
            s1_last_q  <= final_rd;
            if (final_rd) begin
              state_q <= ST_IDLE;
            end else if (rd_addr_q == last_q) begin
              rd_addr_q <= '0;
              if (!inf_q) begin
                rem_q <= rem_q - 16'd1;
              end
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gain_ext = {{SAMPLE_W{gain_q[SAMPLE_W-1]}}, gain_q};

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < NUMBER_OF_LINE; i++) begin
      prod_d[i] = $signed({{SAMPLE_W{rd_data[(i+1)*SAMPLE_W-1]}}, rd_data[i*SAMPLE_W +: SAMPLE_W]})
                  * gain_ext;
    end
  end

  always_comb begin
    dac_data_d = '0;
    if (s2_valid_q && !stop) begin
      for (int i = 0; i < NUMBER_OF_LINE; i++) begin
        dac_data_d[i*SAMPLE_W +: SAMPLE_W] = saturate(prod_q[i]);
      end
    end
  end

  // Stop squashes every stage on the same edge, so no sample already in flight ever reaches the DAC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      prod_q      <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      s2_valid_q  <= s1_valid_q && !stop;
      s2_last_q   <= s1_last_q && !stop;
      prod_q      <= prod_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= s2_valid_q && !stop;
      done_q      <= s2_valid_q && s2_last_q && !stop;
    end
  end

  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = (state_q != ST_PLAY);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tx_playback_core.sv
// Directed bench for tx_playback_core: a gain/saturation vector table plus sequences for
// looping, stop, reset abort and write dropping.
module tb_tx_playback_core;
  import tx_core_pkg::*;

  localparam int NL = 8;
  localparam int DL = 10;
  localparam int WW = 16 * NL;

  logic          clock;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [DL-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [DL-1:0] last_addr;
  logic [15:0]   loop_count;
  logic [15:0]   gain;
  logic          arm;
  logic          trigger;
  logic          stop;
  logic [WW-1:0] dac_data;
  logic          dac_valid;
  logic          busy;
  logic          done;
  tx_state_e     state_dbg;

  logic [WW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] gain;
    logic [15:0] samp;
    logic [15:0] expv;
  } vec_t;
  vec_t vecs[11];

  tx_playback_core #(.NUMBER_OF_LINE(NL), .DEPTH_LOG2(DL)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_addr  (last_addr),
    .loop_count (loop_count),
    .gain       (gain),
    .arm        (arm),
    .trigger    (trigger),
    .stop       (stop),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WW-1:0] rep(input logic [15:0] v);
    logic [WW-1:0] w;
    for (int l = 0; l < NL; l++) w[l*16 +: 16] = v;
    return w;
  endfunction

  function automatic logic [WW-1:0] pat_a(input int a);
    logic [WW-1:0] w;
    for (int l = 0; l < NL; l++) w[l*16 +: 16] = 16'(100 * a + l);
    return w;
  endfunction

  // A gain of 0x7FFF scales by (1 - 2^-15), so every positive value floors to one below itself.
  function automatic logic [WW-1:0] pat_a_exp(input int a);
    logic [WW-1:0] w;
    int v;
    for (int l = 0; l < NL; l++) begin
      v = 100 * a + l;
      w[l*16 +: 16] = (v == 0) ? 16'd0 : 16'(v - 1);
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] pat_b(input int a);
    logic [WW-1:0] w;
    for (int l = 0; l < NL; l++) w[l*16 +: 16] = 16'(4096 + 16 * a + l);
    return w;
  endfunction

  function automatic logic [WW-1:0] pat_b_exp(input int a);
    logic [WW-1:0] w;
    for (int l = 0; l < NL; l++) w[l*16 +: 16] = 16'(4096 + 16 * a + l - 1);
    return w;
  endfunction

  // driver tasks
  task automatic load_word(input int a, input logic [WW-1:0] d);
    wr_addr  = DL'(a);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_play(input int la, input logic [15:0] lc, input logic [15:0] g);
    last_addr  = DL'(la);
    loop_count = lc;
    gain       = g;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_ready", wr_ready, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("trig_ready", wr_ready, 0);
  endtask

  // scoreboard: two empty cycles, then one expected word per clock until the queue is empty
  task automatic play_check(input string tag, input bit finite);
    logic [WW-1:0] exp_w;
    bit exp_done;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check({tag, "_lat"}, dac_valid, 0);
    end
    while (exp_q.size() > 0) begin
      tick();
      exp_w    = exp_q.pop_front();
      exp_done = finite && (exp_q.size() == 0);
      check({tag, "_valid"}, dac_valid, 1);
      check({tag, "_data"}, dac_data, exp_w);
      check({tag, "_done"}, done, exp_done);
    end
    if (finite) begin
      check({tag, "_busy_end"}, busy, 0);
      tick();
      check({tag, "_tail_valid"}, dac_valid, 0);
      check({tag, "_tail_data"}, dac_data, 0);
      check({tag, "_tail_done"}, done, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h7FFF, 16'd300,  16'd299};
    vecs[1]  = '{16'h8000, 16'h8000, 16'h7FFF};
    vecs[2]  = '{16'h8000, 16'h4000, 16'hC000};
    vecs[3]  = '{16'h4000, 16'd1001, 16'd500};
    vecs[4]  = '{16'h4000, 16'hFC17, 16'hFE0B};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE};
    vecs[6]  = '{16'h7FFF, 16'h8000, 16'h8001};
    vecs[7]  = '{16'h0000, 16'd1234, 16'h0000};
    vecs[8]  = '{16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[9]  = '{16'h8000, 16'h7FFF, 16'h8001};
    vecs[10] = '{16'h2000, 16'h0007, 16'h0001};

    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    last_addr = '0; loop_count = '0; gain = '0;
    arm = 1'b0; trigger = 1'b0; stop = 1'b0;
    repeat (3) tick();
    check("rst_valid", dac_valid, 0);
    check("rst_data", dac_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    tick();

    // IDLE and ARMED control corners
    trigger = 1'b1; tick(); trigger = 1'b0;
    check("idle_trig_busy", busy, 0);
    arm = 1'b1; trigger = 1'b1; tick(); arm = 1'b0; trigger = 1'b0;
    check("arm_trig_busy", busy, 1);
    check("arm_trig_ready", wr_ready, 1);
    tick();
    check("armed_hold", state_dbg, ST_ARMED);
    stop = 1'b1; trigger = 1'b1; tick(); stop = 1'b0; trigger = 1'b0;
    check("stop_armed_busy", busy, 0);
    tick();
    check("stop_armed_valid", dac_valid, 0);

    // four words, one pass
    for (int a = 0; a < 4; a++) load_word(a, pat_a(a));
    for (int a = 0; a < 4; a++) exp_q.push_back(pat_a_exp(a));
    start_play(3, 16'd1, 16'h7FFF);
    play_check("basic", 1);

    // three passes over two words, no gap at the wrap
    for (int n = 0; n < 3; n++)
      for (int a = 0; a < 2; a++) exp_q.push_back(pat_a_exp(a));
    start_play(1, 16'd3, 16'h7FFF);
    play_check("loop3", 1);

    // gain / saturation table, single-word waveform
    for (int i = 0; i < 11; i++) begin
      load_word(0, rep(vecs[i].samp));
      exp_q.push_back(rep(vecs[i].expv));
      start_play(0, 16'd1, vecs[i].gain);
      play_check($sformatf("vec%0d", i), 1);
    end

    // infinite loop, stop after 10 PLAY cycles
    for (int a = 0; a < 4; a++) load_word(a, pat_a(a));
    start_play(3, 16'd0, 16'h7FFF);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k >= 3) begin
        check("inf_valid", dac_valid, 1);
        check("inf_data", dac_data, pat_a_exp((k - 3) % 4));
      end else begin
        check("inf_lat", dac_valid, 0);
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_valid", dac_valid, 0);
    check("stop_data", dac_data, 0);
    check("stop_done", done, 0);
    check("stop_ready", wr_ready, 1);
    check("stop_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("squash_valid", dac_valid, 0);
      check("squash_done", done, 0);
    end

    // reset in PLAY; a write offered during PLAY must not land
    for (int a = 0; a < 4; a++) load_word(a, pat_b(a));
    start_play(3, 16'd0, 16'h7FFF);
    wr_addr = DL'(1); wr_data = '1; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_valid", dac_valid, 1);
    reset = 1'b1;
    #2;
    check("arst_valid", dac_valid, 0);
    check("arst_data", dac_data, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", wr_ready, 1);
    check("arst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) exp_q.push_back(pat_b_exp(a));
    start_play(3, 16'd1, 16'h7FFF);
    play_check("replay", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
